// File: rtl/miriscv_interrupt_controller.sv
// Single-level interrupt controller: picks the lowest-index enabled request, strobes the core, acks on mret.
// Build option: define MIRISCV_INT_EDGE_EN for edge-captured requests; the default build uses level requests.
module miriscv_interrupt_controller (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] int_req_i,
    input  logic [31:0] mie_i,
    input  logic        int_en_i,
    input  logic        int_fin_i,
    output logic        int_o,
    output logic [31:0] mcause_o,
    output logic [31:0] int_ack_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pending_s;
    logic [31:0] eligible_s;
    logic [4:0]  sel_id_s;
    logic        sel_valid_s;
    logic        fin_s;
    logic [4:0]  id_r;
    logic        int_next_s;
    logic [31:0] mcause_next_s;
    logic [31:0] ack_next_s;

    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [31:0] one_hot(input logic [4:0] idx);
        return 32'h0000_0001 << idx;
    endfunction

    assign fin_s = (state_r == SERVE) && int_fin_i;

`ifdef MIRISCV_INT_EDGE_EN
    logic [31:0] req_prev_r;
    logic [31:0] pending_r;
    logic [31:0] rise_s;
    logic [31:0] clear_s;

    assign rise_s    = int_req_i & ~req_prev_r;
    assign clear_s   = fin_s ? one_hot(id_r) : 32'h0000_0000;
    assign pending_s = pending_r;

    // Edge capture; a fresh rise on the bit being acked wins over its clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_prev_r <= 32'h0000_0000;
            pending_r  <= 32'h0000_0000;
        end else begin
            req_prev_r <= int_req_i;
            pending_r  <= (pending_r & ~clear_s) | rise_s;
        end
    end
`else
    assign pending_s = int_req_i;
`endif

    assign eligible_s  = pending_s & mie_i;
    assign sel_id_s    = lowest_set(eligible_s);
    assign sel_valid_s = (state_r == IDLE) && int_en_i && (eligible_s != 32'h0000_0000);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: no nesting, so SERVE only leaves on mret.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sel_valid_s) begin
                    state_next_s = SERVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE: begin
                if (int_fin_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Serviced source id, frozen for the whole SERVE phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_r <= 5'd0;
        end else if (sel_valid_s) begin
            id_r <= sel_id_s;
        end else begin
            id_r <= id_r;
        end
    end

    // Output decode; mcause keeps its last value until the next selection.
    always_comb begin
        int_next_s    = 1'b0;
        mcause_next_s = mcause_o;
        ack_next_s    = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (sel_valid_s) begin
                    int_next_s    = 1'b1;
                    mcause_next_s = {1'b1, 26'd0, sel_id_s};
                end else begin
                    int_next_s    = 1'b0;
                end
            end
            SERVE: begin
                if (fin_s) begin
                    ack_next_s = one_hot(id_r);
                end else begin
                    ack_next_s = 32'h0000_0000;
                end
            end
            default: begin
                int_next_s = 1'b0;
                ack_next_s = 32'h0000_0000;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_o     <= 1'b0;
            mcause_o  <= 32'h0000_0000;
            int_ack_o <= 32'h0000_0000;
        end else begin
            int_o     <= int_next_s;
            mcause_o  <= mcause_next_s;
            int_ack_o <= ack_next_s;
        end
    end

endmodule

// File: doc/miriscv_interrupt_controller.md
MIRISCV_INTERRUPT_CONTROLLER -- requirements
Module: miriscv_interrupt_controller

Interface
REQ-001 Parameters: none; the request vector width SHALL be fixed at 32.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 int_req_i  input  32  peripheral interrupt request lines, bit n = source n.
REQ-005 mie_i  input  32  per-source enable mask from the core's mie CSR.
REQ-006 int_en_i  input  1  global enable from mstatus.MIE.
REQ-007 int_fin_i  input  1  one-cycle pulse from the core on mret, meaning the handler is finished.
REQ-008 int_o  output  1  one-cycle interrupt strobe to the core.
REQ-009 mcause_o  output  32  cause for the core's mcause CSR: {1'b1, 26'b0, id[4:0]}.
REQ-010 int_ack_o  output  32  one-hot acknowledge to the serviced source, one-cycle pulse.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and SERVE.
REQ-012 Eligible vector: eligible = pending & mie_i. The source SHALL be the lowest set index of eligible (bit 0 has highest priority).
REQ-013 IDLE -> SERVE when eligible != 0 and int_en_i = 1: latch id, drive int_o = 1 for exactly one cycle, and update mcause_o.
REQ-014 IDLE with eligible = 0 or int_en_i = 0: stay in IDLE; int_o = 0.
REQ-015 In SERVE, mcause_o SHALL be held constant, int_o SHALL stay 0, and no new source SHALL be selected (no nesting).
REQ-016 In SERVE, changes on mie_i and int_en_i SHALL NOT affect the latched id.
REQ-017 SERVE -> IDLE on int_fin_i = 1: int_ack_o = (1 << id) for one cycle, in the cycle after int_fin_i is sampled.
REQ-018 int_fin_i in IDLE SHALL be ignored; int_ack_o stays 0.
REQ-019 Masked sources (mie_i bit = 0) SHALL NOT be lost: in edge mode they stay pending until unmasked and served.
REQ-020 mcause_o SHALL retain its last value after returning to IDLE until the next selection.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-022 While rst_i = 1 at a clock edge:
- the FSM goes to IDLE;
- pending and the edge-history register clear to 0;
- int_o = 0, int_ack_o = 0, mcause_o = 32'h0.
REQ-023 Reset asserted during SERVE SHALL abort service with no int_ack_o pulse.
REQ-024 The first selection after reset release SHALL be possible at the first edge with rst_i = 0.

Configuration
REQ-025 Macro MIRISCV_INT_EDGE_EN selects the request capture mode.
REQ-026 MIRISCV_INT_EDGE_EN defined (edge mode):
- pending[n] SHALL set at the edge where int_req_i[n] = 1 and the previous sampled value = 0;
- pending[n] SHALL clear together with the int_ack_o[n] pulse;
- if a new rising edge on the same bit coincides with the clear, set wins;
- latency from the int_req_i rise to int_o = 2 cycles.
REQ-027 MIRISCV_INT_EDGE_EN undefined (level mode):
- pending = int_req_i, sampled each cycle; there SHALL be no pending storage;
- the source holds its line until it sees int_ack_o;
- latency from int_req_i high to int_o = 1 cycle.

Verification
REQ-028 Edge mode, mie_i = 32'h2, int_en_i = 1: int_req_i[1] rises -> int_o pulses after 2 cycles, mcause_o = 32'h8000_0001; then int_fin_i pulse -> int_ack_o = 32'h2 the next cycle, FSM returns to IDLE.
REQ-029 Requests 32'h0000_0014 arriving in the same cycle, mie_i = all ones -> serve id 2 first (mcause_o = 32'h8000_0002); after int_fin_i, int_o pulses again with mcause_o = 32'h8000_0004.
REQ-030 int_req_i[3] pulses while mie_i[3] = 0, then mie_i = 32'h8 ten cycles later (edge mode) -> int_o fires, mcause_o = 32'h8000_0003.
REQ-031 int_en_i = 0 with an eligible request -> int_o stays 0 for 20 cycles; setting int_en_i = 1 -> int_o fires in the next cycle.
REQ-032 rst_i asserted for 1 cycle during SERVE -> all outputs 0, no int_ack_o pulse, a later int_fin_i is ignored, pending is cleared.
REQ-033 int_fin_i pulsed in IDLE -> no int_ack_o; the second int_req_i edge in SERVE coinciding with int_ack_o on the same bit -> the bit remains pending and is re-served.
